// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared types and constants for the 5-stage MIPS pipeline control logic.
//   state_t      : hazard controller states (RUN, MEM_WAIT, ERROR)
//   REG_ADDR_W   : width of a register-file address field
//   ctrl_t       : per-cycle pipeline control vector (enables and flushes)
//   CTRL_RUN     : normal advance, no bubbles
//   CTRL_FREEZE  : everything held, no bubbles
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_m_en;
        logic m_wb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                      id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                      ex_m_en: 1'b1, m_wb_en: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Flags a load in EX whose destination is a source of the instruction in ID.
// Register 0 is hard-wired to zero, so a load "into" r0 never creates a hazard.
//   ex_mem_read : instruction in EX is a load
//   ex_wr       : destination register of the EX instruction
//   id_rs/id_rt : source register fields of the ID instruction
//   load_use    : hazard present (combinational)
// -----------------------------------------------------------------------------
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_wr,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  load_use
);

    assign load_use = ex_mem_read && (ex_wr != '0) && ((ex_wr == id_rs) || (ex_wr == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage MIPS pipeline. Drives the PC
// and pipeline-register enables/flushes from hazard conditions:
//   - data-memory wait states freeze the whole pipe (highest priority)
//   - taken branch in EX flushes IF/ID and ID/EX
//   - load-use hazard inserts a single ID/EX bubble
//   - a memory access waiting MEM_TIMEOUT cycles traps into sticky ERROR
// Outputs are combinational from state and inputs; all outputs are 0 while rst.
// Ports:
//   clk, rst (sync, active-high)
//   ID_Rs, ID_Rt, EX_MemRead, EX_WR_out, EX_Branch_taken : hazard sources
//   M_MemRead, M_MemWrite, dm_ready                      : data memory status
//   dm_req, PC_en, IF_ID_en/flush, ID_EX_en/flush, EX_M_en, M_WB_en, err
// Build option: define HAZARD_PERF_EN to add saturating stall counters
//   perf_mem_stall / perf_lu_stall (not counted in ERROR).
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_WR_out,
    input  logic                  EX_Branch_taken,
    input  logic                  M_MemRead,
    input  logic                  M_MemWrite,
    input  logic                  dm_ready,
    output logic                  dm_req,
    output logic                  PC_en,
    output logic                  IF_ID_en,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_en,
    output logic                  ID_EX_flush,
    output logic                  EX_M_en,
    output logic                  M_WB_en,
    output logic                  err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_mem_stall,
    output logic [31:0]           perf_lu_stall
`endif
);

    // Widened by one bit so the incremented count cannot wrap before the compare.
    localparam logic [CNT_W:0] TIMEOUT_V = MEM_TIMEOUT[CNT_W:0];

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             mem_acc;
    logic             load_use;
    logic             freeze;
    logic             dm_req_c;
    logic             err_c;
    ctrl_t            ctrl;

    load_use_detect u_lud (
        .ex_mem_read (EX_MemRead),
        .ex_wr       (EX_WR_out),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .load_use    (load_use)
    );

    assign mem_acc = M_MemRead | M_MemWrite;
    assign cnt_inc = {1'b0, wait_cnt} + 1'b1;

    always_comb begin
        ctrl     = CTRL_RUN;
        dm_req_c = 1'b0;
        freeze   = 1'b0;
        err_c    = 1'b0;
        case (state)
            RUN: begin
                dm_req_c = mem_acc;
                freeze   = mem_acc & ~dm_ready;
            end
            MEM_WAIT: begin
                dm_req_c = 1'b1;
                freeze   = ~dm_ready;
            end
            default: begin
                err_c = 1'b1;
            end
        endcase

        // Freeze beats branch beats load-use; a frozen EX keeps its branch until release.
        if (err_c || freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (EX_Branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end

        if (rst) begin
            ctrl     = CTRL_FREEZE;
            dm_req_c = 1'b0;
            err_c    = 1'b0;
        end
    end

    assign dm_req      = dm_req_c;
    assign err         = err_c;
    assign PC_en       = ctrl.pc_en;
    assign IF_ID_en    = ctrl.if_id_en;
    assign IF_ID_flush = ctrl.if_id_flush;
    assign ID_EX_en    = ctrl.id_ex_en;
    assign ID_EX_flush = ctrl.id_ex_flush;
    assign EX_M_en     = ctrl.ex_m_en;
    assign M_WB_en     = ctrl.m_wb_en;

    // wait_cnt holds the number of wait cycles already spent, including the
    // RUN cycle in which the stall started.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dm_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= cnt_inc[CNT_W-1:0];
                        if (cnt_inc >= TIMEOUT_V) begin
                            state <= ERROR;
                        end
                    end
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_bubble;

    assign lu_bubble = ~err_c & ~freeze & ~EX_Branch_taken & load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_stall <= '0;
            perf_lu_stall  <= '0;
        end else begin
            if (freeze && (perf_mem_stall != '1)) begin
                perf_mem_stall <= perf_mem_stall + 32'd1;
            end
            if (lu_bubble && (perf_lu_stall != '1)) begin
                perf_lu_stall <= perf_lu_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by randomized traffic, each cycle compared with
// a behavioural model of the stall/flush rules. Runs with MEM_TIMEOUT=4.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_Rs, ID_Rt, EX_WR_out;
    logic       EX_MemRead, EX_Branch_taken, M_MemRead, M_MemWrite, dm_ready;
    logic       dm_req, PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush;
    logic       EX_M_en, M_WB_en, err;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_mem_stall, perf_lu_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: a pending memory access, cycles waited so far, trapped flag.
    bit      m_pend = 0;
    bit      m_err  = 0;
    int      m_wait = 0;
    longint  m_perf_mem = 0;
    longint  m_perf_lu  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_Rs           (ID_Rs),
        .ID_Rt           (ID_Rt),
        .EX_MemRead      (EX_MemRead),
        .EX_WR_out       (EX_WR_out),
        .EX_Branch_taken (EX_Branch_taken),
        .M_MemRead       (M_MemRead),
        .M_MemWrite      (M_MemWrite),
        .dm_ready        (dm_ready),
        .dm_req          (dm_req),
        .PC_en           (PC_en),
        .IF_ID_en        (IF_ID_en),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_en        (ID_EX_en),
        .ID_EX_flush     (ID_EX_flush),
        .EX_M_en         (EX_M_en),
        .M_WB_en         (M_WB_en),
        .err             (err)
`ifdef HAZARD_PERF_EN
        ,
        .perf_mem_stall  (perf_mem_stall),
        .perf_lu_stall   (perf_lu_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs against the model, then
    // advance the model as the clock edge will.
    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                        input bit exmr, input logic [4:0] exwr, input bit br,
                        input bit mrd, input bit mwr, input bit rdy, input string tag);
        bit         acc, lu, frz, bubble;
        logic [8:0] exp;
        @(negedge clk);
        rst = r; ID_Rs = rs; ID_Rt = rt; EX_MemRead = exmr; EX_WR_out = exwr;
        EX_Branch_taken = br; M_MemRead = mrd; M_MemWrite = mwr; dm_ready = rdy;
        #1;
        acc    = mrd | mwr;
        lu     = exmr && (exwr != 0) && (exwr == rs || exwr == rt);
        frz    = !r && !m_err && (m_pend || acc) && !rdy;
        bubble = !r && !m_err && !frz && !br && lu;
        // {dm_req, PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_M_en, M_WB_en, err}
        if (r)          exp = 9'b0;
        else if (m_err) exp = 9'b0_0000000_1;
        else begin
            exp[8] = m_pend ? 1'b1 : acc;
            if (frz)       exp[7:0] = 8'b0000000_0;
            else if (br)   exp[7:0] = 8'b1111111_0;
            else if (lu)   exp[7:0] = 8'b0001111_0;
            else           exp[7:0] = 8'b1101011_0;
        end
        chk(tag, {dm_req, PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
                  EX_M_en, M_WB_en, err}, {55'd0, exp});
`ifdef HAZARD_PERF_EN
        if (!r) begin
            chk({tag, "_pmem"}, {32'd0, perf_mem_stall}, m_perf_mem);
            chk({tag, "_plu"},  {32'd0, perf_lu_stall},  m_perf_lu);
        end
`endif
        if (r) begin
            m_pend = 0; m_err = 0; m_wait = 0; m_perf_mem = 0; m_perf_lu = 0;
        end else begin
            if (frz && m_perf_mem < 64'hFFFF_FFFF) m_perf_mem++;
            if (bubble && m_perf_lu < 64'hFFFF_FFFF) m_perf_lu++;
            if (!m_err) begin
                if (frz && m_pend) begin
                    m_wait++;
                    if (m_wait >= MT) begin
                        m_err  = 1;
                        m_pend = 0;
                    end
                end else if (frz) begin
                    m_pend = 1;
                    m_wait = 1;
                end else begin
                    m_pend = 0;
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic idle(input string tag);
        step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, tag);
    endtask

    initial begin
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "reset");
        chk("reset_pc", PC_en, 0);
        idle("idle0");
        chk("idle_pc", PC_en, 1);
        chk("idle_err", err, 0);

        // load r5 in EX, add r6,r5,r1 in ID
        step(0, 5'd5, 5'd1, 1, 5'd5, 0, 0, 0, 1, "lu_bubble");
        chk("lu_pc", PC_en, 0);
        chk("lu_ifid_en", IF_ID_en, 0);
        chk("lu_idex_fl", ID_EX_flush, 1);
        chk("lu_exm_en", EX_M_en, 1);
        step(0, 5'd5, 5'd1, 0, 5'd6, 0, 1, 0, 1, "lu_after");
        chk("lu_after_pc", PC_en, 1);

        // load r0: no hazard
        step(0, 5'd0, 5'd3, 1, 5'd0, 0, 0, 0, 1, "lu_r0");
        chk("lu_r0_pc", PC_en, 1);

        // three wait cycles, release on the fourth
        for (int i = 0; i < 3; i++) begin
            step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "memw");
            chk("memw_req", dm_req, 1);
            chk("memw_pc", PC_en, 0);
        end
        step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1, "mem_rel");
        chk("mem_rel_mwb", M_WB_en, 1);
        step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "mem_run");
        chk("mem_run_req", dm_req, 0);

        // branch overrides load-use
        step(0, 5'd7, 5'd2, 1, 5'd7, 1, 0, 0, 1, "br_lu");
        chk("br_lu_pc", PC_en, 1);
        chk("br_lu_iffl", IF_ID_flush, 1);

        // branch held through a memory wait, acted on at release
        step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 0, "br_wait");
        chk("br_wait_iffl", IF_ID_flush, 0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 1, "br_rel");
        chk("br_rel_iffl", IF_ID_flush, 1);

        // hung memory traps into ERROR after MT wait cycles
        for (int i = 0; i < MT + 2; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "tmo");
        chk("tmo_err", err, 1);
        step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1, "tmo_hold");
        chk("tmo_hold_err", err, 1);
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "tmo_rst");
        idle("tmo_run");
        chk("tmo_run_err", err, 0);

        // reset in the middle of a memory wait
        step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "mw_a");
        step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "mw_b");
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, "mw_rst");
        chk("mw_rst_req", dm_req, 0);
        step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, "mw_after");
        chk("mw_after_req", dm_req, 0);
`ifdef HAZARD_PERF_EN
        chk("perf_mem_zero", perf_mem_stall, 0);
        chk("perf_lu_zero", perf_lu_stall, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, exmr, br, mrd, mwr, rdy;
            logic [4:0] rs, rt, exwr;
            r    = ($urandom_range(99) < 2);
            rs   = 5'($urandom_range(3));
            rt   = 5'($urandom_range(3));
            exwr = 5'($urandom_range(3));
            exmr = ($urandom_range(99) < 40);
            br   = ($urandom_range(99) < 15);
            mrd  = ($urandom_range(99) < 30);
            mwr  = ($urandom_range(99) < 15);
            rdy  = ($urandom_range(99) < 55);
            step(r, rs, rt, exmr, exwr, br, mrd, mwr, rdy, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
